// File: rtl/regfile_write_ctrl.sv
// Write-back controller for the 32x32 register file: arbitrates ALU and load-unit
// write requests into a small FIFO, drains one entry per cycle and answers hazard queries.
module regfile_write_ctrl #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int ADDRW = 5
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             AluValid,
  output logic             AluReady,
  input  logic [ADDRW-1:0] AluReg,
  input  logic [WIDTH-1:0] AluData,
  input  logic             MemValid,
  output logic             MemReady,
  input  logic [ADDRW-1:0] MemReg,
  input  logic [WIDTH-1:0] MemData,
  input  logic             WbStall,
  output logic [ADDRW-1:0] WriteRegister,
  output logic [WIDTH-1:0] WriteData,
  output logic             RegWrite,
  input  logic [ADDRW-1:0] QueryReg1,
  input  logic [ADDRW-1:0] QueryReg2,
  output logic             Pending1,
  output logic             Pending2,
  output logic [WIDTH-1:0] FwdData1,
  output logic [WIDTH-1:0] FwdData2,
  output logic [ADDRW-1:0] Count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [ADDRW-1:0] regMem_r  [DEPTH];
  logic [WIDTH-1:0] dataMem_r [DEPTH];
  logic [PW-1:0]    headPtr_r;
  logic [PW-1:0]    tailPtr_r;
  logic [CW-1:0]    count_r;

  logic             notFull_s;
  logic             memFire_s;
  logic             aluFire_s;
  logic [ADDRW-1:0] pushReg_s;
  logic [WIDTH-1:0] pushData_s;
  logic             push_s;
  logic             pop_s;

  // Ready reflects occupancy before any pop, so a full FIFO refuses input while draining.
  assign notFull_s = (count_r < CW'(DEPTH));
  assign MemReady  = Reset_n & notFull_s;
  assign AluReady  = Reset_n & notFull_s & ~MemValid;
  assign memFire_s = MemValid & MemReady;
  assign aluFire_s = AluValid & AluReady;
  assign pop_s     = (count_r != {CW{1'b0}}) & ~WbStall;
  assign Count     = ADDRW'(count_r);

  // Select the accepted request; writes to $0 handshake but are dropped here.
  always_comb begin
    pushReg_s  = {ADDRW{1'b0}};
    pushData_s = {WIDTH{1'b0}};
    if (memFire_s) begin
      pushReg_s  = MemReg;
      pushData_s = MemData;
    end else if (aluFire_s) begin
      pushReg_s  = AluReg;
      pushData_s = AluData;
    end else begin
      pushReg_s  = {ADDRW{1'b0}};
      pushData_s = {WIDTH{1'b0}};
    end
    push_s = (memFire_s | aluFire_s) & (pushReg_s != {ADDRW{1'b0}});
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      headPtr_r <= {PW{1'b0}};
      tailPtr_r <= {PW{1'b0}};
      count_r   <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        tailPtr_r <= tailPtr_r + PW'(1);
      end
      if (pop_s) begin
        headPtr_r <= headPtr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; cleared on reset so nothing stale can be forwarded.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regMem_r[i]  <= {ADDRW{1'b0}};
        dataMem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_s) begin
      regMem_r[tailPtr_r]  <= pushReg_s;
      dataMem_r[tailPtr_r] <= pushData_s;
    end
  end

  // Head entry drives the regfile write port directly; the port is zeroed when idle.
  always_comb begin
    RegWrite      = pop_s;
    WriteRegister = {ADDRW{1'b0}};
    WriteData     = {WIDTH{1'b0}};
    if (pop_s) begin
      WriteRegister = regMem_r[headPtr_r];
      WriteData     = dataMem_r[headPtr_r];
    end else begin
      WriteRegister = {ADDRW{1'b0}};
      WriteData     = {WIDTH{1'b0}};
    end
  end

  // Hazard lookup: walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    Pending1 = 1'b0;
    Pending2 = 1'b0;
    FwdData1 = {WIDTH{1'b0}};
    FwdData2 = {WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] idx;
      logic          live;
      logic          hit1;
      logic          hit2;
      idx      = headPtr_r + PW'(i);
      live     = (CW'(i) < count_r);
      hit1     = live & (QueryReg1 != {ADDRW{1'b0}}) & (regMem_r[idx] == QueryReg1);
      hit2     = live & (QueryReg2 != {ADDRW{1'b0}}) & (regMem_r[idx] == QueryReg2);
      Pending1 = Pending1 | hit1;
      Pending2 = Pending2 | hit2;
      FwdData1 = hit1 ? dataMem_r[idx] : FwdData1;
      FwdData2 = hit2 ? dataMem_r[idx] : FwdData2;
    end
  end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Scoreboard bench for regfile_write_ctrl: directed scenarios followed by random traffic,
// checked against a queue-based reference of the write-back buffer.
module tb_regfile_write_ctrl;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int ADDRW = 5;

  typedef struct {
    logic [ADDRW-1:0] r;
    logic [WIDTH-1:0] d;
  } entry_t;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic             AluValid = 1'b0;
  logic             AluReady;
  logic [ADDRW-1:0] AluReg = '0;
  logic [WIDTH-1:0] AluData = '0;
  logic             MemValid = 1'b0;
  logic             MemReady;
  logic [ADDRW-1:0] MemReg = '0;
  logic [WIDTH-1:0] MemData = '0;
  logic             WbStall = 1'b0;
  logic [ADDRW-1:0] WriteRegister;
  logic [WIDTH-1:0] WriteData;
  logic             RegWrite;
  logic [ADDRW-1:0] QueryReg1 = '0;
  logic [ADDRW-1:0] QueryReg2 = '0;
  logic             Pending1;
  logic             Pending2;
  logic [WIDTH-1:0] FwdData1;
  logic [WIDTH-1:0] FwdData2;
  logic [ADDRW-1:0] Count;

  regfile_write_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDRW(ADDRW)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .AluValid(AluValid), .AluReady(AluReady), .AluReg(AluReg), .AluData(AluData),
    .MemValid(MemValid), .MemReady(MemReady), .MemReg(MemReg), .MemData(MemData),
    .WbStall(WbStall),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .QueryReg1(QueryReg1), .QueryReg2(QueryReg2),
    .Pending1(Pending1), .Pending2(Pending2), .FwdData1(FwdData1), .FwdData2(FwdData2),
    .Count(Count)
  );

  always #5 Clk = ~Clk;

  entry_t sb[$];
  entry_t pend;
  bit     pendV = 1'b0;
  int     total = 0;
  int     bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; an accepted request joins the model at the following edge.
  task automatic step(input logic rn, input logic aV, input logic [ADDRW-1:0] aR,
                      input logic [WIDTH-1:0] aD, input logic mV, input logic [ADDRW-1:0] mR,
                      input logic [WIDTH-1:0] mD, input logic st,
                      input logic [ADDRW-1:0] q1, input logic [ADDRW-1:0] q2);
    @(posedge Clk);
    if (pendV) sb.push_back(pend);
    pendV = 1'b0;
    #1;
    Reset_n = rn; AluValid = aV; AluReg = aR; AluData = aD;
    MemValid = mV; MemReg = mR; MemData = mD; WbStall = st;
    QueryReg1 = q1; QueryReg2 = q2;
    if (!rn) begin
      sb.delete();
    end else if (sb.size() < DEPTH) begin
      if (mV) begin
        if (mR != '0) begin pend.r = mR; pend.d = mD; pendV = 1'b1; end
      end else if (aV) begin
        if (aR != '0) begin pend.r = aR; pend.d = aD; pendV = 1'b1; end
      end
    end
  endtask

  task automatic idle(input int n, input logic st, input logic [ADDRW-1:0] q1);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, st, q1, '0);
  endtask

  // Monitor: compares every output against the model mid-cycle, popping on expected writes.
  always @(negedge Clk) begin
    int n;
    bit expRdy, expRw, p1, p2;
    logic [WIDTH-1:0] d1, d2;
    entry_t e;
    n = sb.size();
    expRdy = (Reset_n === 1'b1) && (n < DEPTH);
    chk("MemReady", 64'(MemReady), 64'(expRdy));
    chk("AluReady", 64'(AluReady), 64'(expRdy && !MemValid));
    chk("Count", 64'(Count), 64'(n));
    chk("CountBound", 64'(Count <= ADDRW'(DEPTH)), 64'd1);
    p1 = 1'b0; p2 = 1'b0; d1 = '0; d2 = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!p1 && QueryReg1 != '0 && sb[i].r == QueryReg1) begin p1 = 1'b1; d1 = sb[i].d; end
      if (!p2 && QueryReg2 != '0 && sb[i].r == QueryReg2) begin p2 = 1'b1; d2 = sb[i].d; end
    end
    chk("Pending1", 64'(Pending1), 64'(p1));
    chk("Pending2", 64'(Pending2), 64'(p2));
    chk("FwdData1", 64'(FwdData1), 64'(d1));
    chk("FwdData2", 64'(FwdData2), 64'(d2));
    expRw = (n > 0) && !WbStall;
    chk("RegWrite", 64'(RegWrite), 64'(expRw));
    if (expRw) begin
      e = sb.pop_front();
      chk("WriteRegister", 64'(WriteRegister), 64'(e.r));
      chk("WriteData", 64'(WriteData), 64'(e.d));
    end else begin
      chk("WriteRegisterIdle", 64'(WriteRegister), 64'd0);
      chk("WriteDataIdle", 64'(WriteData), 64'd0);
    end
  end

  initial begin
    // reset, then reset again with three entries held by a stall
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    for (int i = 1; i <= 3; i++)
      step(1'b1, 1'b1, ADDRW'(i), WIDTH'(i * 16), 1'b0, '0, '0, 1'b1, 5'd2, '0);
    idle(1, 1'b1, 5'd2);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd2, '0);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd2, '0);
    idle(3, 1'b0, 5'd2);

    // single ALU write
    step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, 5'd5, '0);
    idle(3, 1'b0, 5'd5);

    // Mem beats Alu; Alu retried next cycle
    step(1'b1, 1'b1, 5'd4, 32'h22, 1'b1, 5'd3, 32'h11, 1'b0, 5'd3, 5'd4);
    step(1'b1, 1'b1, 5'd4, 32'h22, 1'b0, '0, '0, 1'b0, 5'd3, 5'd4);
    idle(3, 1'b0, 5'd4);

    // fill to same register under stall, refuse when full, then drain
    for (int i = 1; i <= 4; i++)
      step(1'b1, 1'b1, 5'd7, WIDTH'(i), 1'b0, '0, '0, 1'b1, 5'd7, '0);
    step(1'b1, 1'b1, 5'd7, 32'h99, 1'b1, 5'd7, 32'h98, 1'b1, 5'd7, 5'd7);
    idle(6, 1'b0, 5'd7);

    // $0 write handshakes but is dropped
    step(1'b1, 1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0, 1'b0, '0, '0);
    idle(3, 1'b0, '0);

    // full FIFO draining while Mem keeps offering
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, '0, '0, 1'b1, ADDRW'(8 + i), WIDTH'(32'h100 + i), 1'b1, 5'd9, '0);
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, '0, '0, 1'b1, ADDRW'(12 + i), WIDTH'(32'h200 + i), 1'b0, 5'd13, 5'd9);
    idle(6, 1'b0, '0);

    // random traffic with occasional resets
    for (int c = 0; c < 3000; c++)
      step(1'($urandom_range(0, 249) != 0),
           1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 99) < 40), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 99) < 40),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    idle(8, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_ctrl.md
Name: regfile_write_ctrl

Overview:
Write-side controller for the 32x32 MIPS register file. It accepts register write-back requests from two producers (ALU and load unit) over valid/ready handshakes and buffers them in a small FIFO. It drains the FIFO one entry per cycle into the register file's single synchronous write port (WriteRegister/WriteData/RegWrite). It also reports pending writes and the youngest buffered data for two read addresses, which feeds hazard detection and forwarding.

Parameters:
DEPTH, 4, number of FIFO entries (power of two, >=2)
WIDTH, 32, data width
ADDRW, 5, register address width

Ports:
Clk  input  1  clock; all state updates on posedge
Reset_n  input  1  asynchronous active-low reset
AluValid  input  1  ALU write request valid
AluReady  output  1  ALU request accepted this cycle when AluValid and AluReady are both high
AluReg  input  ADDRW  ALU destination register
AluData  input  WIDTH  ALU result
MemValid  input  1  load-unit write request valid
MemReady  output  1  load-unit request accepted this cycle when MemValid and MemReady are both high
MemReg  input  ADDRW  load destination register
MemData  input  WIDTH  load data
WbStall  input  1  blocks draining (write port lent elsewhere)
WriteRegister  output  ADDRW  to regfile write address
WriteData  output  WIDTH  to regfile write data
RegWrite  output  1  to regfile write enable
QueryReg1  input  ADDRW  hazard query address 1
QueryReg2  input  ADDRW  hazard query address 2
Pending1  output  1  buffered write to QueryReg1 exists
Pending2  output  1  buffered write to QueryReg2 exists
FwdData1  output  WIDTH  data of youngest buffered entry matching QueryReg1
FwdData2  output  WIDTH  data of youngest buffered entry matching QueryReg2
Count  output  ADDRW  occupancy, 0..DEPTH

Behaviour:
- Reset (Reset_n low, asynchronous):
  - Pointers and Count go to 0 and every buffered entry is discarded.
  - RegWrite=0, WriteRegister=0, WriteData=0, Pending1/2=0, FwdData1/2=0.
  - AluReady=0 and MemReady=0 while Reset_n is low.
  - If reset is asserted mid-drain, no further RegWrite occurs for the discarded entries.
- Enqueue: at most one per cycle, with fixed priority Mem over Alu.
  - MemReady = Reset_n & (Count<DEPTH).
  - AluReady = Reset_n & (Count<DEPTH) & ~MemValid.
- $0 writes: a request with Reg==0 completes its handshake (ready as above) but is not enqueued and does not change Count.
- Drain: when Count>0 and WbStall=0:
  - RegWrite=1; WriteRegister and WriteData are the head entry (combinational from FIFO state).
  - The head pops on the same posedge at which the regfile captures it.
  - When empty or stalled: RegWrite=0 and WriteRegister/WriteData=0.
- Latency: a request accepted at edge N drives RegWrite during cycle N..N+1 if the FIFO was empty, so the regfile is updated at edge N+1.
- Simultaneous push and pop in one cycle: Count is unchanged. Ready is based on Count before the pop, so a full FIFO refuses input even while draining.
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH and never underflows.
- Ordering: entries are written in acceptance order. Two writes to the same register both reach the regfile, and the later one wins.
- Query:
  - PendingK = (QueryRegK != 0) and at least one valid entry has Reg==QueryRegK.
  - FwdDataK = data of the youngest such entry, else 0.
  - Query results are purely combinational on FIFO contents and QueryRegK, and do not include the request being offered this cycle.

Test Plan:
- Reset with Count=3 buffered and WbStall=1, then release Reset_n and WbStall -> RegWrite stays 0, Count=0, Pending1=0.
- AluValid, AluReg=5, AluData=0xDEADBEEF for one cycle, WbStall=0 -> next cycle RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF; following cycle RegWrite=0, Count=0.
- MemValid and AluValid both high (Mem reg 3 = 0x11, Alu reg 4 = 0x22) -> MemReady=1, AluReady=0; Mem entry is written first; Alu is accepted the next cycle and written after.
- WbStall=1 and enqueue reg 7 = 0x1, 0x2, 0x3, 0x4 -> Count=4, both readies 0, QueryReg1=7 gives Pending1=1 and FwdData1=0x4; release the stall -> four consecutive RegWrite cycles with data 1,2,3,4.
- AluReg=0, AluData=0xFFFF with AluValid -> AluReady=1, Count stays 0, RegWrite never asserts; QueryReg2=0 -> Pending2=0.
- Full FIFO with WbStall=0 and MemValid held high -> one pop per cycle; MemReady is high only on cycles where Count<4, and Count never exceeds 4.
